// File: rtl/fetch_stage_pkg.sv
// Shared opcode constants, BHT counter encodings and predecode helpers for the IF stage.
package fetch_stage_pkg;

    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Saturating step of a 2-bit counter toward the resolved outcome.
    function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
        ctr_e nxt;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] code);
        return {{19{code[31]}}, code[31], code[7], code[30:25], code[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] code);
        return {{11{code[31]}}, code[31], code[19:12], code[20], code[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_stage_branch_history_table.sv
// Untagged table of 2-bit saturating counters: combinational read, synchronous update.
module branch_history_table
    import fetch_stage_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output ctr_e             rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    ctr_e ctr_r [ENTRIES];

    assign rd_ctr = ctr_r[rd_idx];

    // Counter array: all entries return to weakly not-taken on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_r[i] <= WNT;
            end
        end else if (wr_en) begin
            ctr_r[wr_idx] <= ctr_next(ctr_r[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, predecode with BHT-based branch prediction, next-PC selection
// and EX-stage redirect handling.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] code_IM,
    output logic [31:0] PC,
    output logic        prediction,
    input  logic        ex_update,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic        ex_mispredict,
    input  logic [31:0] ex_redirect,
    output logic        clear_if_id
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [31:0] pc_r;
    logic [31:0] next_pc_s;
    logic [31:0] target_s;
    logic [31:0] pc_plus4_s;
    logic        prediction_s;
    ctr_e        rd_ctr_s;
    logic        unused_bits_s;

    branch_history_table #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (pc_r[IDX_W+1:2]),
        .rd_ctr   (rd_ctr_s),
        .wr_en    (ex_update),
        .wr_idx   (ex_pc[IDX_W+1:2]),
        .wr_taken (ex_taken)
    );

    assign pc_plus4_s    = pc_r + 32'd4;
    assign unused_bits_s = ^{ex_pc[31:IDX_W+2], ex_pc[1:0], ex_redirect[1:0]};

    // Predecode: only B-type consults the BHT; JAL is always taken; JALR is left to EX.
    always_comb begin
        target_s     = pc_plus4_s;
        prediction_s = 1'b0;
        case (code_IM[6:0])
            OP_BRANCH: begin
                target_s     = pc_r + imm_b(code_IM);
                prediction_s = rd_ctr_s[1];
            end
            OP_JAL: begin
                target_s     = pc_r + imm_j(code_IM);
                prediction_s = 1'b1;
            end
            default: begin
                target_s     = pc_plus4_s;
                prediction_s = 1'b0;
            end
        endcase
    end

    // Next-PC priority: EX redirect beats stall, stall beats prediction.
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (ex_mispredict) begin
            next_pc_s = {ex_redirect[31:2], 2'b00};
        end else if (!enable) begin
            next_pc_s = pc_r;
        end else if (prediction_s) begin
            next_pc_s = {target_s[31:2], 2'b00};
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    assign PC          = pc_r;
    assign prediction  = prediction_s;
    assign clear_if_id = ex_mispredict;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: sequencing, stall, BHT learning,
// saturation, JAL, redirect under stall, wrap, same-index collision, aliasing, mid-run reset.
module tb_fetch_stage;

    localparam logic [31:0] NOP_W = 32'h0000_0013;
    localparam logic [31:0] BEQ_W = 32'hFE00_08E3;  // beq x0,x0,-16
    localparam logic [31:0] JAL_W = 32'h1000_006F;  // jal x0,+0x100

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] code_IM;
    logic [31:0] PC;
    logic        prediction;
    logic        ex_update;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic        ex_mispredict;
    logic [31:0] ex_redirect;
    logic        clear_if_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .code_IM       (code_IM),
        .PC            (PC),
        .prediction    (prediction),
        .ex_update     (ex_update),
        .ex_pc         (ex_pc),
        .ex_taken      (ex_taken),
        .ex_mispredict (ex_mispredict),
        .ex_redirect   (ex_redirect),
        .clear_if_id   (clear_if_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] addr);
        ex_mispredict = 1'b1;
        ex_redirect   = addr;
        step();
        ex_mispredict = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; code_IM = NOP_W;
        ex_update = 1'b0; ex_pc = 32'd0; ex_taken = 1'b0;
        ex_mispredict = 1'b0; ex_redirect = 32'd0;
        #2;
        chk("rst_pc", PC, 32'h0);
        chk("rst_pred", {31'd0, prediction}, 32'd0);
        chk("rst_clr", {31'd0, clear_if_id}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Sequential fetch
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("seq_pc", PC, 32'(i * 4));
            chk("seq_pred", {31'd0, prediction}, 32'd0);
        end

        // Stall at 0x10
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", PC, 32'h10);
        end
        enable = 1'b1;
        step();
        chk("unstall_pc", PC, 32'h14);
        step(); step(); step();
        chk("walk_pc", PC, 32'h20);

        // Cold branch predicts not-taken
        code_IM = BEQ_W; #1;
        chk("cold_pred", {31'd0, prediction}, 32'd0);
        step();
        chk("cold_next", PC, 32'h24);

        // Train taken twice
        code_IM = NOP_W; ex_update = 1'b1; ex_pc = 32'h20; ex_taken = 1'b1;
        step(); step();
        ex_update = 1'b0;
        redirect(32'h20);
        chk("redir_pc", PC, 32'h20);
        code_IM = BEQ_W; #1;
        chk("warm_pred", {31'd0, prediction}, 32'd1);
        step();
        chk("warm_next", PC, 32'h10);

        // Saturation: 5 taken then 1 not-taken -> WT
        code_IM = NOP_W; enable = 1'b0; ex_update = 1'b1; ex_pc = 32'h20; ex_taken = 1'b1;
        repeat (5) step();
        ex_taken = 1'b0;
        step();
        ex_update = 1'b0;
        chk("sat_stall_pc", PC, 32'h10);
        enable = 1'b1;
        redirect(32'h20);
        code_IM = BEQ_W; #1;
        chk("sat_pred", {31'd0, prediction}, 32'd1);
        step();
        chk("sat_next", PC, 32'h10);

        // One more not-taken -> WNT
        code_IM = NOP_W; ex_update = 1'b1; ex_taken = 1'b0; ex_pc = 32'h20;
        step();
        ex_update = 1'b0;
        redirect(32'h20);
        code_IM = BEQ_W; #1;
        chk("wnt_pred", {31'd0, prediction}, 32'd0);
        step();
        chk("wnt_next", PC, 32'h24);

        // JAL
        redirect(32'h40);
        code_IM = JAL_W; #1;
        chk("jal_pred", {31'd0, prediction}, 32'd1);
        step();
        chk("jal_next", PC, 32'h140);

        // Mispredict while stalled
        code_IM = NOP_W; enable = 1'b0;
        ex_mispredict = 1'b1; ex_redirect = 32'h203; #1;
        chk("mp_clr", {31'd0, clear_if_id}, 32'd1);
        step();
        chk("mp_pc", PC, 32'h200);
        ex_mispredict = 1'b0; #1;
        chk("mp_clr_off", {31'd0, clear_if_id}, 32'd0);
        enable = 1'b1;

        // Wrap
        redirect(32'hFFFF_FFFC);
        chk("wrap_at", PC, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc", PC, 32'h0);

        // Same-index read and update
        redirect(32'h20);
        code_IM = BEQ_W; enable = 1'b0;
        ex_update = 1'b1; ex_pc = 32'h20; ex_taken = 1'b1; #1;
        chk("coll_old", {31'd0, prediction}, 32'd0);
        step();
        ex_update = 1'b0; #1;
        chk("coll_new", {31'd0, prediction}, 32'd1);
        chk("coll_pc", PC, 32'h20);

        // Alias: 0x120 shares the counter of 0x20
        redirect(32'h120);
        code_IM = BEQ_W; enable = 1'b1; #1;
        chk("alias_pred", {31'd0, prediction}, 32'd1);
        step();
        chk("alias_next", PC, 32'h110);

        // Asynchronous reset mid-run clears PC and BHT
        reset = 1'b0; #1;
        chk("mid_rst_pc", PC, 32'h0);
        #1 reset = 1'b1;
        redirect(32'h20);
        code_IM = BEQ_W; #1;
        chk("mid_rst_pred", {31'd0, prediction}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
